// File: rtl/lcd_delay_status.sv
// lcd_delay_status: formats the ADC alignment delays, DA reader run state and
// DIP setting as two 16-character ASCII rows and writes them to the LCD port.
// A refresh runs only when a displayed value changes, and a holdoff counter
// limits how often refreshes can start.
//
// Ports:
//   clkcomm, RST          clock, asynchronous active-low reset
//   ad1_delay, ad2_delay  ADC1/ADC2 alignment delays (clkcomm domain)
//   ad_valid_delay        valid-strobe delay (clkcomm domain)
//   reader_da_start       DA reader running flag (clkcomm domain)
//   dip                   raw DIP switches (asynchronous, synchronized here)
//   lcd_row/col/char/we   character write port, one lcd_we per character
//   lcd_update            one-cycle commit pulse after all 32 characters
//   lcd_busy              LCD driver busy; stalls lcd_we and lcd_update
module lcd_delay_status #(
  parameter logic [23:0] HOLDOFF = 24'd1_000_000
) (
  input  logic       clkcomm,
  input  logic       RST,
  input  logic [3:0] ad1_delay,
  input  logic [3:0] ad2_delay,
  input  logic [3:0] ad_valid_delay,
  input  logic       reader_da_start,
  input  logic [7:0] dip,
  output logic       lcd_row,
  output logic [3:0] lcd_col,
  output logic [7:0] lcd_char,
  output logic       lcd_we,
  output logic       lcd_update,
  input  logic       lcd_busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
    S_UPDATE = 2'd2,
    S_WAIT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  dip_meta, dip_sync;
  logic [20:0] live, snap_q;
  logic        dirty_q;
  logic [4:0]  idx_q;
  logic [23:0] holdoff_q;
  logic        wait_cnt_q;
  logic        do_latch, do_write, do_update;
  logic [7:0]  char_d;

  // The synchronizer is deliberately left out of reset so it keeps tracking
  // the switches while RST is low; the refresh that starts on the first edge
  // after release then already shows the real DIP setting.
  always_ff @(posedge clkcomm) begin
    dip_meta <= dip;
    dip_sync <= dip_meta;
  end

  assign live = {ad1_delay, ad2_delay, ad_valid_delay, reader_da_start, dip_sync};

  // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  // Character for the current index, taken from the snapshot only so that
  // input changes during a refresh never mix old and new text on the glass.
  always_comb begin
    char_d = 8'h20;
    if (!idx_q[4]) begin
      unique case (idx_q[3:0])
        4'd0:    char_d = "A";
        4'd1:    char_d = "1";
        4'd2:    char_d = "=";
        4'd3:    char_d = hex_ascii(snap_q[20:17]);
        4'd5:    char_d = "A";
        4'd6:    char_d = "2";
        4'd7:    char_d = "=";
        4'd8:    char_d = hex_ascii(snap_q[16:13]);
        4'd10:   char_d = "A";
        4'd11:   char_d = "V";
        4'd12:   char_d = "=";
        4'd13:   char_d = hex_ascii(snap_q[12:9]);
        default: char_d = 8'h20;
      endcase
    end else begin
      unique case (idx_q[3:0])
        4'd0:    char_d = "D";
        4'd1:    char_d = "A";
        4'd2:    char_d = ":";
        4'd3:    char_d = snap_q[8] ? "R" : "S";
        4'd4:    char_d = snap_q[8] ? "U" : "T";
        4'd5:    char_d = snap_q[8] ? "N" : "O";
        4'd6:    char_d = snap_q[8] ? 8'h20 : "P";
        4'd8:    char_d = "D";
        4'd9:    char_d = "I";
        4'd10:   char_d = "P";
        4'd11:   char_d = "=";
        4'd12:   char_d = hex_ascii(snap_q[7:4]);
        4'd13:   char_d = hex_ascii(snap_q[3:0]);
        default: char_d = 8'h20;
      endcase
    end
  end

  // FSM next-state and per-cycle strobes.
  always_comb begin
    state_d   = state_q;
    do_latch  = 1'b0;
    do_write  = 1'b0;
    do_update = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dirty_q && (holdoff_q == 24'd0)) begin
          do_latch = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!lcd_busy) begin
          do_write = 1'b1;
          if (idx_q == 5'd31) state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!lcd_busy) begin
          do_update = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // wait_cnt_q marks that the first WAIT cycle has passed
        if (wait_cnt_q && !lcd_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      snap_q     <= '0;
      dirty_q    <= 1'b1;
      idx_q      <= '0;
      holdoff_q  <= '0;
      wait_cnt_q <= 1'b0;
    end else begin
      // Latching the live inputs makes the snapshot match them, so dirty is
      // cleared even if a compare would have set it in the same cycle.
      if (do_latch) begin
        snap_q  <= live;
        dirty_q <= 1'b0;
      end else if ((state_q == S_IDLE) && (live != snap_q)) begin
        dirty_q <= 1'b1;
      end

      if (do_latch)      idx_q <= '0;
      else if (do_write) idx_q <= idx_q + 5'd1;

      if (do_update)                  holdoff_q <= HOLDOFF;
      else if (holdoff_q != 24'd0)    holdoff_q <= holdoff_q - 24'd1;

      if (do_update)               wait_cnt_q <= 1'b0;
      else if (state_q == S_WAIT)  wait_cnt_q <= 1'b1;
    end
  end

  // Registered LCD port; row/col/char hold their last values between writes.
  always_ff @(posedge clkcomm or negedge RST) begin
    if (!RST) begin
      lcd_row    <= 1'b0;
      lcd_col    <= 4'd0;
      lcd_char   <= 8'h20;
      lcd_we     <= 1'b0;
      lcd_update <= 1'b0;
    end else begin
      lcd_we     <= do_write;
      lcd_update <= do_update;
      if (do_write) begin
        lcd_row  <= idx_q[4];
        lcd_col  <= idx_q[3:0];
        lcd_char <= char_d;
      end
    end
  end

endmodule

// File: tb/tb_lcd_delay_status.sv
module tb_lcd_delay_status;

  localparam int HO = 100;

  logic       clkcomm = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] ad1_delay = '0, ad2_delay = '0, ad_valid_delay = '0;
  logic       reader_da_start = 1'b0;
  logic [7:0] dip = '0;
  logic       lcd_row;
  logic [3:0] lcd_col;
  logic [7:0] lcd_char;
  logic       lcd_we, lcd_update;
  logic       lcd_busy = 1'b0;

  lcd_delay_status #(.HOLDOFF(24'd100)) dut (
    .clkcomm(clkcomm), .RST(RST),
    .ad1_delay(ad1_delay), .ad2_delay(ad2_delay), .ad_valid_delay(ad_valid_delay),
    .reader_da_start(reader_da_start), .dip(dip),
    .lcd_row(lcd_row), .lcd_col(lcd_col), .lcd_char(lcd_char),
    .lcd_we(lcd_we), .lcd_update(lcd_update), .lcd_busy(lcd_busy)
  );

  always #5 clkcomm = ~clkcomm;

  typedef struct packed {
    logic [3:0]   ad1, ad2, adv;
    logic         da;
    logic [7:0]   dip;
    logic [127:0] row0, row1;
  } vec_t;

  vec_t vecs [0:8];

  int checks = 0, errors = 0;
  int cyc = 0, upd_count = 0, upd_cyc = 0, first_we_cyc = 0;
  int writes_this = 0, last_writes = 0;
  logic busy_seen = 1'b0;
  logic [12:0] q[$];
  logic [12:0] mon_e;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ad1_delay = v.ad1; ad2_delay = v.ad2; ad_valid_delay = v.adv;
    reader_da_start = v.da; dip = v.dip;
  endtask

  // Scoreboard: 32 expected {row,col,char} records per refresh
  task automatic push_exp(input vec_t v);
    for (int i = 0; i < 32; i++) begin
      int col;
      logic [7:0] ch;
      col = i % 16;
      ch  = (i >= 16) ? v.row1[127 - 8*col -: 8] : v.row0[127 - 8*col -: 8];
      q.push_back({(i >= 16) ? 1'b1 : 1'b0, 4'(col), ch});
    end
  endtask

  task automatic wait_updates(input int target);
    int n;
    n = 0;
    while (upd_count < target && n < 1000) begin
      @(posedge clkcomm); #1; n++;
    end
    if (upd_count < target) begin
      checks++; errors++;
      $display("FAIL update_timeout: got %0d updates, expected %0d", upd_count, target);
    end
  endtask

  task automatic wait_write(input logic row, input logic [3:0] col);
    int n;
    n = 0;
    do begin
      @(posedge clkcomm); #1; n++;
    end while (!(lcd_we && lcd_row == row && lcd_col == col) && n < 1000);
    if (!(lcd_we && lcd_row == row && lcd_col == col)) begin
      checks++; errors++;
      $display("FAIL write_timeout: row %0d col %0d never written", row, col);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row"}, lcd_row, 0);
    chk({tag, "_col"}, lcd_col, 0);
    chk({tag, "_char"}, lcd_char, 8'h20);
    chk({tag, "_we"}, lcd_we, 0);
    chk({tag, "_update"}, lcd_update, 0);
  endtask

  always @(posedge clkcomm) begin
    cyc++;
    busy_seen = lcd_busy;
  end

  // Monitor: pops the scoreboard on every write, counts update pulses
  always @(negedge clkcomm) begin
    if (!RST) begin
      writes_this = 0;
    end else begin
      if (busy_seen) chk("busy_gate", {lcd_we, lcd_update}, 0);
      if (lcd_we) begin
        if (writes_this == 0) first_we_cyc = cyc;
        writes_this++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got r%0d c%0d ch %0h, expected no write",
                   lcd_row, lcd_col, lcd_char);
        end else begin
          mon_e = q.pop_front();
          chk($sformatf("char_r%0d_c%0d", mon_e[12], mon_e[11:8]),
              {lcd_row, lcd_col, lcd_char}, mon_e);
        end
      end
      if (lcd_update) begin
        upd_count++;
        upd_cyc = cyc;
        last_writes = writes_this;
        writes_this = 0;
      end
    end
  end

  initial begin
    int n0, u0, gap;
    vecs[0] = '{4'h2, 4'h0, 4'h0, 1'b0, 8'h00, "A1=2 A2=0 AV=0  ", "DA:STOP DIP=00  "};
    vecs[1] = '{4'hB, 4'h0, 4'h0, 1'b0, 8'h00, "A1=B A2=0 AV=0  ", "DA:STOP DIP=00  "};
    vecs[2] = '{4'hB, 4'hF, 4'h0, 1'b0, 8'hFF, "A1=B A2=F AV=0  ", "DA:STOP DIP=FF  "};
    vecs[3] = '{4'h9, 4'hA, 4'hC, 1'b1, 8'h3C, "A1=9 A2=A AV=C  ", "DA:RUN  DIP=3C  "};
    vecs[4] = '{4'h0, 4'h1, 4'hE, 1'b0, 8'hD7, "A1=0 A2=1 AV=E  ", "DA:STOP DIP=D7  "};
    vecs[5] = '{4'h3, 4'h4, 4'h5, 1'b0, 8'h12, "A1=3 A2=4 AV=5  ", "DA:STOP DIP=12  "};
    vecs[6] = '{4'h3, 4'h4, 4'h5, 1'b1, 8'h12, "A1=3 A2=4 AV=5  ", "DA:RUN  DIP=12  "};
    vecs[7] = '{4'h7, 4'h8, 4'h6, 1'b1, 8'hA5, "A1=7 A2=8 AV=6  ", "DA:RUN  DIP=A5  "};
    vecs[8] = '{4'h1, 4'h2, 4'h3, 1'b0, 8'h00, "A1=1 A2=2 AV=3  ", "DA:STOP DIP=00  "};

    // Reset values, then the refresh that follows release
    drive(vecs[0]);
    repeat (4) @(posedge clkcomm);
    #1;
    check_reset_outputs("reset");
    push_exp(vecs[0]);
    RST = 1'b1;
    wait_updates(1);
    chk("reset_refresh_writes", last_writes, 32);

    // Table-driven refreshes: change inputs 10 cycles after the last update
    for (int k = 1; k <= 4; k++) begin
      n0 = upd_count;
      u0 = upd_cyc;
      repeat (10) @(posedge clkcomm);
      #1;
      drive(vecs[k]);
      push_exp(vecs[k]);
      wait_updates(n0 + 1);
      chk($sformatf("vec%0d_writes", k), last_writes, 32);
      gap = first_we_cyc - u0;
      chk($sformatf("vec%0d_holdoff_gap_ok", k), (gap > HO && gap <= HO + 4) ? 1 : 0, 1);
    end

    // Busy stall at index 7
    n0 = upd_count;
    repeat (10) @(posedge clkcomm);
    #1;
    drive(vecs[8]);
    push_exp(vecs[8]);
    wait_write(1'b0, 4'd6);
    lcd_busy = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(posedge clkcomm); #1;
      chk($sformatf("stall_we_%0d", s), lcd_we, 0);
    end
    lcd_busy = 1'b0;
    @(posedge clkcomm); #1;
    chk("stall_resume", {lcd_we, lcd_row, lcd_col, lcd_char}, {1'b1, 1'b0, 4'd7, 8'h3D});
    wait_updates(n0 + 1);
    chk("stall_writes", last_writes, 32);

    // DA flag toggled mid-refresh: current refresh keeps STOP, next shows RUN
    n0 = upd_count;
    repeat (10) @(posedge clkcomm);
    #1;
    drive(vecs[5]);
    push_exp(vecs[5]);
    wait_write(1'b1, 4'd4);
    reader_da_start = 1'b1;
    push_exp(vecs[6]);
    wait_updates(n0 + 1);
    chk("mid_first_writes", last_writes, 32);
    wait_updates(n0 + 2);
    chk("mid_second_writes", last_writes, 32);

    // Reset asserted at index 15
    n0 = upd_count;
    repeat (10) @(posedge clkcomm);
    #1;
    drive(vecs[7]);
    push_exp(vecs[7]);
    wait_write(1'b0, 4'd15);
    RST = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    repeat (3) @(posedge clkcomm);
    #1;
    push_exp(vecs[7]);
    RST = 1'b1;
    wait_updates(n0 + 1);
    chk("midreset_writes", last_writes, 32);

    // Nothing changes afterwards: no further writes or updates
    n0 = upd_count;
    repeat (300) @(posedge clkcomm);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("no_extra_update", upd_count, n0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
